// File: rtl/rrarb_ctrl.sv
// Round-robin owner sequencer for a single shared resource: one-hot registered grant,
// optional hold limit with forced release, and a fixed idle turnaround between owners.
module rrarb_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned TURN_CYC = 1,
    localparam int unsigned IdW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           ck,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IdW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    localparam logic [7:0]     MaxHold = 8'(MAX_HOLD);
    localparam logic [3:0]     TurnCyc = 4'(TURN_CYC);
    localparam logic [IdW-1:0] LastId  = IdW'(N - 1);

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [7:0]     hold_cnt_q, hold_cnt_d;
    logic [3:0]     turn_cnt_q, turn_cnt_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IdW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic           timeout_q, timeout_d;

    logic           pick_found;
    logic [IdW-1:0] pick_id;
    logic [IdW-1:0] cand;
    int unsigned    cand_idx;
    logic           owner_req;
    logic           force_rel;

    // First requester found scanning upward from ptr, wrapping at N.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        cand_idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand_idx = (32'(ptr_q) + i) % N;
            cand     = IdW'(cand_idx);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign owner_req = req[gnt_id_q];
    assign force_rel = owner_req && (MAX_HOLD != 0) && (hold_cnt_q == MaxHold);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        grant_d    = grant_q;
        gnt_id_d   = gnt_id_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    gnt_id_d         = pick_id;
                    busy_d           = 1'b1;
                    hold_cnt_d       = 8'd1;
                    state_d          = StGrant;
                end
            end
            StGrant: begin
                if (!owner_req || force_rel) begin
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    timeout_d = force_rel;
                    ptr_d     = (gnt_id_q == LastId) ? '0 : gnt_id_q + IdW'(1);
                    if (TURN_CYC != 0) begin
                        turn_cnt_d = TurnCyc;
                        state_d    = StTurn;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hold_cnt_q != 8'hff) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            StTurn: begin
                if (turn_cnt_q <= 4'd1) begin
                    turn_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            grant_q    <= '0;
            gnt_id_q   <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            grant_q    <= grant_d;
            gnt_id_q   <= gnt_id_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
